// File: rtl/fir_pkg.sv
// ============================================================================
//  fir_pkg : shared widths, defaults and the round/saturate helper for the
//            FIR datapath.
//  Rev 1.0
// ============================================================================
`default_nettype none

package fir_pkg;

    localparam int CW_DEF   = 16;
    localparam int SW_DEF   = 3;
    localparam int TAPS_DEF = 10;
    localparam int OW_DEF   = 16;

    typedef struct packed {
        logic [63:0] val;
        logic        ovf;
    } sat_t;

    function automatic int acc_width(input int cw, input int sw, input int taps);
        return cw + sw + $clog2(taps);
    endfunction

    function automatic int cnt_width(input int taps);
        return $clog2(taps + 1) + 1;
    endfunction

    // Round half up by SHIFT, then clamp into a signed ow-bit range.
    function automatic sat_t sat_round(input logic signed [63:0] v,
                                       input int shift, input int ow);
        sat_t               res;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (shift > 0)
            r = (v + (64'sd1 <<< (shift - 1))) >>> shift;
        else
            r = v;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        res.ovf = 1'b0;
        res.val = r;
        if (r > hi) begin
            res.val = hi;
            res.ovf = 1'b1;
        end else if (r < lo) begin
            res.val = lo;
            res.ovf = 1'b1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_sat_round.sv
// ============================================================================
//  mac_sat_round : combinational round-half-up shift and saturation, AW -> OW.
//  Rev 1.0
// ============================================================================
`default_nettype none

module mac_sat_round
    import fir_pkg::*;
#(
    parameter int AW    = 22,
    parameter int OW    = OW_DEF,
    parameter int SHIFT = 0
) (
    input  logic signed [AW-1:0] i_acc,
    output logic        [OW-1:0] o_mac,
    output logic                 o_ovf
);

    logic signed [63:0] w_ext;
    sat_t               w_res;
    logic [63-OW:0]     w_unused_hi;

    assign w_ext       = 64'(i_acc);
    assign w_res       = sat_round(w_ext, SHIFT, OW);
    assign o_mac       = w_res.val[OW-1:0];
    assign o_ovf       = w_res.ovf;
    assign w_unused_hi = w_res.val[63:OW];

endmodule

`default_nettype wire

// File: rtl/mac_pipe_param.sv
// ============================================================================
//  mac_pipe_param : three-stage pipelined signed MAC, one frame of taps per
//                   result, with round/saturate output and tap overrun flag.
//  Rev 1.0
// ============================================================================
`default_nettype none

module mac_pipe_param
    import fir_pkg::*;
#(
    parameter int CW    = CW_DEF,
    parameter int SW    = SW_DEF,
    parameter int TAPS  = TAPS_DEF,
    parameter int OW    = OW_DEF,
    parameter int SHIFT = 0
) (
    input  logic          iClk_12M,
    input  logic          iRsn,
    input  logic          iEn,
    input  logic          iValid,
    input  logic          iFirst,
    input  logic          iLast,
    input  logic [CW-1:0] iCoeff,
    input  logic [SW-1:0] iSample,
    output logic [OW-1:0] oMac,
    output logic          oValid,
    output logic          oOvf,
    output logic          oErr
);

    localparam int PW   = CW + SW;
    localparam int AW   = acc_width(CW, SW, TAPS);
    localparam int CNTW = cnt_width(TAPS);

    logic signed [CW-1:0] r_coeff_s1;
    logic signed [SW-1:0] r_sample_s1;
    logic                 r_vld_s1, r_first_s1, r_last_s1;
    logic signed [PW-1:0] r_prod_s2;
    logic                 r_vld_s2, r_first_s2, r_last_s2;
    logic signed [AW-1:0] r_acc;
    logic [CNTW-1:0]      r_cnt;
    logic                 r_err;
    logic [OW-1:0]        r_mac;
    logic                 r_ovf;
    logic                 r_valid;

    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_prod_ext;
    logic signed [AW-1:0] w_acc_next;
    logic [CNTW-1:0]      w_cnt_next;
    logic                 w_err_hit;
    logic [OW-1:0]        w_sat_mac;
    logic                 w_sat_ovf;

    assign w_prod     = PW'(r_coeff_s1) * PW'(r_sample_s1);
    assign w_prod_ext = AW'(r_prod_s2);
    assign w_acc_next = r_first_s2 ? w_prod_ext : r_acc + w_prod_ext;

    // Tap count saturates at all-ones so a runaway frame cannot wrap it back under TAPS.
    always_comb begin
        w_cnt_next = r_cnt;
        w_err_hit  = 1'b0;
        if (r_first_s2) begin
            w_cnt_next = CNTW'(1);
        end else begin
            if (r_cnt != {CNTW{1'b1}})
                w_cnt_next = r_cnt + CNTW'(1);
            w_err_hit = (r_cnt >= CNTW'(TAPS));
        end
    end

    mac_sat_round #(
        .AW    (AW),
        .OW    (OW),
        .SHIFT (SHIFT)
    ) u_sat (
        .i_acc (w_acc_next),
        .o_mac (w_sat_mac),
        .o_ovf (w_sat_ovf)
    );

    always_ff @(posedge iClk_12M) begin
        if (!iRsn) begin
            r_coeff_s1  <= '0;
            r_sample_s1 <= '0;
            r_vld_s1    <= 1'b0;
            r_first_s1  <= 1'b0;
            r_last_s1   <= 1'b0;
            r_prod_s2   <= '0;
            r_vld_s2    <= 1'b0;
            r_first_s2  <= 1'b0;
            r_last_s2   <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_mac       <= '0;
            r_ovf       <= 1'b0;
            r_valid     <= 1'b0;
        end else if (iEn) begin
            r_coeff_s1  <= iCoeff;
            r_sample_s1 <= iSample;
            r_vld_s1    <= iValid;
            r_first_s1  <= iValid & iFirst;
            r_last_s1   <= iValid & iLast;

            r_prod_s2   <= w_prod;
            r_vld_s2    <= r_vld_s1;
            r_first_s2  <= r_first_s1;
            r_last_s2   <= r_last_s1;

            r_valid     <= r_vld_s2 & r_last_s2;
            if (r_vld_s2) begin
                r_acc <= w_acc_next;
                r_cnt <= r_last_s2 ? '0 : w_cnt_next;
                if (w_err_hit)
                    r_err <= 1'b1;
                if (r_last_s2) begin
                    r_mac <= w_sat_mac;
                    r_ovf <= w_sat_ovf;
                end
            end
        end
    end

    // The strobe is held while frozen but never shown during a disabled cycle.
    assign oValid = r_valid & iEn;
    assign oMac   = r_mac;
    assign oOvf   = r_ovf;
    assign oErr   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mac_pipe_param.sv
// ============================================================================
//  tb_mac_pipe_param : table-driven frames plus hand sequences for stalls,
//                      reset, restart, rounding and tap overrun.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_mac_pipe_param;

    logic        clk = 1'b0;
    logic        rsn, en, vld, first, last;
    logic [15:0] coeff;
    logic [2:0]  sample;
    logic [15:0] mac0, mac2;
    logic        v0, v2, ovf0, ovf2, err0, err2;

    always #5 clk = ~clk;

    mac_pipe_param #(.SHIFT(0)) dut0 (
        .iClk_12M(clk), .iRsn(rsn), .iEn(en), .iValid(vld), .iFirst(first),
        .iLast(last), .iCoeff(coeff), .iSample(sample),
        .oMac(mac0), .oValid(v0), .oOvf(ovf0), .oErr(err0));

    mac_pipe_param #(.SHIFT(2)) dut2 (
        .iClk_12M(clk), .iRsn(rsn), .iEn(en), .iValid(vld), .iFirst(first),
        .iLast(last), .iCoeff(coeff), .iSample(sample),
        .oMac(mac2), .oValid(v2), .oOvf(ovf2), .oErr(err2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [15:0] mac;
        logic        ovf;
        logic [15:0] mac2;
        logic        v2;
    } res_t;
    res_t q[$];

    always @(negedge clk) if (v0) q.push_back('{cyc, mac0, ovf0, mac2, v2});

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_tap(input logic [15:0] c, input logic [2:0] s,
                             input logic f, input logic l, output int t);
        coeff = c; sample = s; vld = 1'b1; first = f; last = l;
        @(posedge clk); #1;
        vld = 1'b0; first = 1'b0; last = 1'b0;
        t = cyc;
    endtask

    task automatic expect_result(input string name, input int t_last,
                                 input logic [15:0] emac, input logic eovf,
                                 output res_t r);
        int k = 0;
        while (q.size() == 0 && k < 20) begin @(posedge clk); #1; k++; end
        if (q.size() == 0) begin
            n_chk++;
            $display("FAIL %s timeout: got no oValid expected one within 20 cycles", name);
            r = '{0, 16'h0, 1'b0, 16'h0, 1'b0};
        end else begin
            r = q.pop_front();
            check({name, " latency"}, 32'(r.c - t_last), 32'd2);
            check({name, " mac"}, 32'(r.mac), 32'(emac));
            check({name, " ovf"}, 32'(r.ovf), 32'(eovf));
            idle(3);
            check({name, " single pulse"}, 32'(q.size()), 32'd0);
        end
    endtask

    typedef struct {
        logic [15:0] c;
        logic [2:0]  s;
        int          n;
        logic [15:0] mac;
        logic        ovf;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int   t, ta, tb;
        res_t r;

        tbl[0] = '{16'h0100, 3'd3,   1,  16'h0300, 1'b0};
        tbl[1] = '{16'd1000, 3'b110, 4,  16'hE0C0, 1'b0};
        tbl[2] = '{16'h7FFF, 3'd3,   10, 16'h7FFF, 1'b1};
        tbl[3] = '{16'h7FFF, 3'b100, 10, 16'h8000, 1'b1};
        tbl[4] = '{16'hFFFF, 3'd3,   2,  16'hFFFA, 1'b0};
        tbl[5] = '{16'h8000, 3'b100, 1,  16'h7FFF, 1'b1};
        tbl[6] = '{16'h2000, 3'd3,   1,  16'h6000, 1'b0};
        tbl[7] = '{16'h0001, 3'd1,   10, 16'h000A, 1'b0};

        rsn = 1'b0; en = 1'b1; vld = 1'b0; first = 1'b0; last = 1'b0;
        coeff = '0; sample = '0;
        idle(2);
        check("reset mac", 32'(mac0), 32'd0);
        check("reset valid", 32'(v0), 32'd0);
        check("reset ovf", 32'(ovf0), 32'd0);
        check("reset err", 32'(err0), 32'd0);
        rsn = 1'b1;
        idle(1);

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < tbl[i].n; j++)
                drive_tap(tbl[i].c, tbl[i].s, j == 0, j == tbl[i].n - 1, t);
            expect_result($sformatf("vec%0d", i), t, tbl[i].mac, tbl[i].ovf, r);
        end
        check("no err at TAPS taps", 32'(err0), 32'd0);

        // Rounding: same taps seen through a SHIFT=2 instance.
        drive_tap(16'd7, 3'd1, 1'b1, 1'b1, t);
        expect_result("shift +7", t, 16'h0007, 1'b0, r);
        check("shift2 +7 mac", 32'(r.mac2), 32'h0002);
        check("shift2 +7 valid", 32'(r.v2), 32'd1);
        drive_tap(16'hFFF9, 3'd1, 1'b1, 1'b1, t);
        expect_result("shift -7", t, 16'hFFF9, 1'b0, r);
        check("shift2 -7 mac", 32'(r.mac2), 32'hFFFE);

        // Back-to-back frames with a two-cycle freeze inside the second one.
        drive_tap(16'd100, 3'd1, 1'b1, 1'b0, t);
        drive_tap(16'd200, 3'd2, 1'b0, 1'b0, t);
        drive_tap(16'd300, 3'd3, 1'b0, 1'b1, ta);
        drive_tap(16'hFFCE, 3'b111, 1'b1, 1'b0, t);
        en = 1'b0;
        idle(2);
        en = 1'b1;
        drive_tap(16'd10, 3'b101, 1'b0, 1'b1, tb);
        idle(4);
        check("b2b count", 32'(q.size()), 32'd2);
        if (q.size() == 2) begin
            r = q.pop_front();
            check("b2b A cycle", 32'(r.c - ta), 32'd4);
            check("b2b A mac", 32'(r.mac), 32'h0578);
            r = q.pop_front();
            check("b2b B cycle", 32'(r.c - tb), 32'd2);
            check("b2b B mac", 32'(r.mac), 32'h0014);
        end
        q.delete();

        // A new first tap mid-frame drops the partial sum.
        drive_tap(16'd100, 3'd1, 1'b1, 1'b0, t);
        drive_tap(16'd100, 3'd1, 1'b0, 1'b0, t);
        drive_tap(16'd3,   3'd1, 1'b1, 1'b0, t);
        drive_tap(16'd4,   3'd1, 1'b0, 1'b1, t);
        expect_result("restart", t, 16'h0007, 1'b0, r);

        // Partial frame, an unqualified first/last, then reset.
        drive_tap(16'h0100, 3'd3, 1'b1, 1'b0, t);
        drive_tap(16'h0100, 3'd3, 1'b0, 1'b0, t);
        first = 1'b1; last = 1'b1;
        idle(1);
        first = 1'b0; last = 1'b0;
        drive_tap(16'h0100, 3'd3, 1'b0, 1'b0, t);
        rsn = 1'b0;
        idle(2);
        check("midreset mac", 32'(mac0), 32'd0);
        check("midreset ovf", 32'(ovf0), 32'd0);
        check("midreset err", 32'(err0), 32'd0);
        check("midreset no result", 32'(q.size()), 32'd0);
        rsn = 1'b1;

        drive_tap(16'd5, 3'd1, 1'b0, 1'b1, t);
        expect_result("no-first frame", t, 16'h0005, 1'b0, r);

        // Eleven taps with no last: overrun flag on the eleventh tap's S3 edge.
        for (int j = 0; j < 11; j++)
            drive_tap(16'd1, 3'd1, j == 0, 1'b0, t);
        idle(1);
        check("err after 10th S3", 32'(err0), 32'd0);
        idle(1);
        check("err after 11th S3", 32'(err0), 32'd1);
        idle(5);
        check("err sticky", 32'(err0), 32'd1);
        check("overrun no result", 32'(q.size()), 32'd0);
        rsn = 1'b0;
        idle(1);
        check("err cleared by reset", 32'(err0), 32'd0);
        rsn = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
